decode_stage: RTL

Second pipeline stage, consuming the 32-bit instruction word registered by the fetch stage. Decodes R/M/B-type formats, reads a 32×32 register file with writeback bypass, resolves branches and jumps by redirecting fetch, and detects load-use and branch-operand hazards by stalling fetch. It also traps on illegal opcodes. Its registered ID/EX bundle feeds the execute stage.

---
 rtl/decode_stage.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/decode_stage.sv
// decode_stage: instruction decode, register file with writeback bypass,
// branch resolution, hazard stalls and illegal-opcode trap.
package decode_pkg;
  typedef enum logic [1:0] {
    FLUSH,
    RUN,
    TRAP
  } state_e;

  typedef struct packed {
    logic        valid;
    logic        wen;
    logic        is_load;
    logic        is_store;
    logic [6:0]  op;
    logic [4:0]  dst;
    logic [4:0]  src1;
    logic [4:0]  src2;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
  } id_ex_t;
endpackage

module decode_stage
  import decode_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] insReg,
  output logic        fetch_enable,
  output logic        jump,
  output logic [4:0]  jumpPC,
  output logic        trapPC,
  input  logic        wb_wen,
  input  logic [4:0]  wb_dst,
  input  logic [31:0] wb_data,
  input  logic        mem_wen,
  input  logic [4:0]  mem_dst,
  output logic        ex_valid,
  output logic        ex_wen,
  output logic        ex_is_load,
  output logic        ex_is_store,
  output logic [6:0]  ex_op,
  output logic [4:0]  ex_dst,
  output logic [4:0]  ex_src1,
  output logic [4:0]  ex_src2,
  output logic [31:0] ex_a,
  output logic [31:0] ex_b,
  output logic [31:0] ex_imm
);

  state_e      state_q, state_d;
  id_ex_t      ex_q, ex_d;
  logic [31:0] rf_q [32];

  logic [6:0]  op;
  logic        is_r, is_ld, is_st, is_m;
  logic        is_beq, is_jmp, is_b, illegal;
  logic [4:0]  ra, rb;
  logic [31:0] rd_a, rd_b, imm;
  logic        uses_a, uses_b;
  logic        load_use, hz_a, hz_b, beq_haz;
  logic        taken, fe_c;

  assign op     = insReg[31:25];
  assign is_r   = (op == 7'h00) | (op == 7'h01) | (op == 7'h02);
  assign is_ld  = (op == 7'h10) | (op == 7'h11);
  assign is_st  = (op == 7'h12) | (op == 7'h13);
  assign is_m   = is_ld | is_st;
  assign is_beq = (op == 7'h30);
  assign is_jmp = (op == 7'h31);
  assign is_b   = is_beq | is_jmp;
  assign illegal = ~(is_r | is_m | is_b);

  // Port A: src1/base, or cmpA for branches.
  // Port B: src2, store data, or cmpB.
  assign ra = is_b ? insReg[24:20] : insReg[19:15];
  assign rb = is_r ? insReg[14:10] :
              is_m ? insReg[24:20] : insReg[19:15];

  assign rd_a = (ra == 5'd0) ? '0 :
                (wb_wen && wb_dst == ra) ? wb_data : rf_q[ra];
  assign rd_b = (rb == 5'd0) ? '0 :
                (wb_wen && wb_dst == rb) ? wb_data : rf_q[rb];

  assign imm = is_r ? {{22{insReg[9]}}, insReg[9:0]} :
               is_m ? {{17{insReg[14]}}, insReg[14:0]} : '0;

  // Loads read only the base; JMP reads nothing.
  assign uses_a = is_r | is_m | is_beq;
  assign uses_b = is_r | is_st | is_beq;

  assign load_use = ex_q.valid & ex_q.is_load & (ex_q.dst != 5'd0) &
                    ((uses_a & (ra == ex_q.dst)) |
                     (uses_b & (rb == ex_q.dst)));

  assign hz_a = (ra != 5'd0) &
                ((ex_q.valid & ex_q.wen & (ra == ex_q.dst)) |
                 (mem_wen & (ra == mem_dst)));
  assign hz_b = (rb != 5'd0) &
                ((ex_q.valid & ex_q.wen & (rb == ex_q.dst)) |
                 (mem_wen & (rb == mem_dst)));
  assign beq_haz = is_beq & (hz_a | hz_b);

  assign taken = is_jmp | (is_beq & (rd_a == rd_b));

  // Next state, redirect and the ID/EX bundle to register.
  always_comb begin
    state_d = state_q;
    ex_d    = '0;
    fe_c    = 1'b0;
    jump    = 1'b0;
    jumpPC  = '0;
    unique case (state_q)
      FLUSH: begin
        fe_c    = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        if (illegal) begin
          state_d = TRAP;
        end else if (load_use | beq_haz) begin
          fe_c = 1'b0;
        end else if (is_b) begin
          fe_c = 1'b1;
          if (taken) begin
            jump    = 1'b1;
            jumpPC  = insReg[4:0];
            state_d = FLUSH;
          end
        end else begin
          fe_c          = 1'b1;
          ex_d.valid    = 1'b1;
          ex_d.wen      = is_r | is_ld;
          ex_d.is_load  = is_ld;
          ex_d.is_store = is_st;
          ex_d.op       = op;
          ex_d.dst      = insReg[24:20];
          ex_d.src1     = ra;
          ex_d.src2     = rb;
          ex_d.a        = rd_a;
          ex_d.b        = rd_b;
          ex_d.imm      = imm;
        end
      end
      TRAP: begin
        state_d = TRAP;
      end
      default: state_d = FLUSH;
    endcase
  end

  assign fetch_enable = fe_c & rst_n;
  assign trapPC       = (state_q == TRAP);

  // State and ID/EX pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FLUSH;
      ex_q    <= '0;
    end else begin
      state_q <= state_d;
      ex_q    <= ex_d;
    end
  end

  // Register file; r0 is never written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (wb_wen && wb_dst != 5'd0) begin
      rf_q[wb_dst] <= wb_data;
    end
  end

  assign ex_valid    = ex_q.valid;
  assign ex_wen      = ex_q.wen;
  assign ex_is_load  = ex_q.is_load;
  assign ex_is_store = ex_q.is_store;
  assign ex_op       = ex_q.op;
  assign ex_dst      = ex_q.dst;
  assign ex_src1     = ex_q.src1;
  assign ex_src2     = ex_q.src2;
  assign ex_a        = ex_q.a;
  assign ex_b        = ex_q.b;
  assign ex_imm      = ex_q.imm;

endmodule
